conv3x3_mac_sequencer: RTL and testbench



---
 rtl/conv3x3_mac_sequencer_pkg.sv | 15 +
 rtl/conv3x3_mac_sequencer_mac.sv | 20 ++
 rtl/conv3x3_mac_sequencer.sv | 119 +++++++++++
 tb/tb_conv3x3_mac_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/conv3x3_mac_sequencer_pkg.sv
// Shared constants and state encoding for the 3x3 convolution MAC sequencer.
package conv_pkg;

    localparam int PIX_W  = 8;
    localparam int KTAPS  = 9;
    localparam int COEF_W = PIX_W + 1;
    localparam int ACC_W  = 2 * (PIX_W + 1) + 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/conv3x3_mac_sequencer_mac.sv
// Combinational multiply-accumulate: Sum = Accum + Mult1 * Mult2 (all signed).
module mac #(
    parameter int MULT_SIZE  = 9,
    parameter int ACCUM_SIZE = 22
) (
    input  logic signed [MULT_SIZE-1:0]  Mult1,
    input  logic signed [MULT_SIZE-1:0]  Mult2,
    input  logic signed [ACCUM_SIZE-1:0] Accum,
    output logic signed [ACCUM_SIZE-1:0] Sum
);

    logic signed [2*MULT_SIZE-1:0] product;

    // Full-precision product, sign-extended into the accumulator width
    always_comb begin
        product = Mult1 * Mult2;
        Sum     = Accum + {{(ACCUM_SIZE-2*MULT_SIZE){product[2*MULT_SIZE-1]}}, product};
    end

endmodule

// File: rtl/conv3x3_mac_sequencer.sv
// 3x3 window convolution: one window per transfer, nine taps stepped serially
// through a single MAC. Runtime-writable coefficient bank is snapshotted per window.
// Optional macro CONV_SATURATE_EN: clamp the result to 0..2^PIX_W-1 instead of wrapping.
//
// state | meaning
// IDLE  | ready for a window
// ACCUM | stepping taps 0..8 through the MAC
// OUT   | result presented, waiting for OutReady_i
module conv3x3_mac_sequencer
    import conv_pkg::*;
(
    input  logic                     Clk_i,
    input  logic                     Rst_i,
    input  logic [KTAPS*PIX_W-1:0]   InData_i,
    input  logic                     InValid_i,
    output logic                     InReady_o,
    output logic [PIX_W-1:0]         OutData_o,
    output logic                     OutValid_o,
    input  logic                     OutReady_i,
    input  logic                     CoefWe_i,
    input  logic [3:0]               CoefAddr_i,
    input  logic signed [COEF_W-1:0] CoefData_i,
    output logic                     Busy_o
);

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   mac_sum;
    logic [3:0]                idx_q;
    logic [PIX_W-1:0]          win_q  [KTAPS];
    logic signed [COEF_W-1:0]  bank_q [KTAPS];
    logic signed [COEF_W-1:0]  snap_q [KTAPS];
    logic                      accept;
    logic [PIX_W-1:0]          pix_map;

    assign accept = InValid_i && (state_q == IDLE);

    mac #(
        .MULT_SIZE  (COEF_W),
        .ACCUM_SIZE (ACC_W)
    ) u_mac (
        .Mult1 ($signed({1'b0, win_q[idx_q]})),
        .Mult2 (snap_q[idx_q]),
        .Accum (acc_q),
        .Sum   (mac_sum)
    );

    // State register
    always_ff @(posedge Clk_i) begin
        if (Rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCUM;
            ACCUM:   if (idx_q == 4'(KTAPS-1)) state_d = OUT;
            OUT:     if (OutReady_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: coefficient bank, window/snapshot capture, tap stepping
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            acc_q <= '0;
            idx_q <= '0;
            for (int k = 0; k < KTAPS; k++) begin
                win_q[k]  <= '0;
                bank_q[k] <= '0;
                snap_q[k] <= '0;
            end
        end else begin
            // Snapshot below reads bank_q before this write lands, so a write on
            // the acceptance cycle only affects the next window.
            if (CoefWe_i && (CoefAddr_i < 4'(KTAPS)))
                bank_q[CoefAddr_i] <= CoefData_i;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        for (int k = 0; k < KTAPS; k++) begin
                            win_q[k]  <= InData_i[k*PIX_W +: PIX_W];
                            snap_q[k] <= bank_q[k];
                        end
                        acc_q <= '0;
                        idx_q <= '0;
                    end
                end
                ACCUM: begin
                    acc_q <= mac_sum;
                    idx_q <= (idx_q == 4'(KTAPS-1)) ? 4'd0 : idx_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Map the signed accumulator onto an output pixel
    always_comb begin
`ifdef CONV_SATURATE_EN
        if (acc_q[ACC_W-1])                 pix_map = '0;
        else if (|acc_q[ACC_W-2:PIX_W])     pix_map = '1;
        else                                pix_map = acc_q[PIX_W-1:0];
`else
        pix_map = acc_q[PIX_W-1:0];
`endif
    end

    // Outputs decoded from state
    always_comb begin
        InReady_o  = (state_q == IDLE);
        OutValid_o = (state_q == OUT);
        Busy_o     = (state_q == ACCUM) || (state_q == OUT);
        OutData_o  = (state_q == OUT) ? pix_map : '0;
    end

endmodule

// File: tb/tb_conv3x3_mac_sequencer.sv
// Self-checking bench for conv3x3_mac_sequencer; honours CONV_SATURATE_EN in its model.
module tb_conv3x3_mac_sequencer;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [71:0]        in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [7:0]         out_data;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               coef_we = 1'b0;
    logic [3:0]         coef_addr = '0;
    logic signed [8:0]  coef_data = '0;
    logic               busy;

    int tests = 0;
    int fails = 0;

    logic signed [8:0] bank [9];
    logic signed [8:0] snap [9];

    conv3x3_mac_sequencer dut (
        .Clk_i      (clk),
        .Rst_i      (rst),
        .InData_i   (in_data),
        .InValid_i  (in_valid),
        .InReady_o  (in_ready),
        .OutData_o  (out_data),
        .OutValid_o (out_valid),
        .OutReady_i (out_ready),
        .CoefWe_i   (coef_we),
        .CoefAddr_i (coef_addr),
        .CoefData_i (coef_data),
        .Busy_o     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: dot product of the window with the snapshot, then map to a pixel
    function automatic logic [7:0] model(input logic [71:0] w, input logic signed [8:0] c [9]);
        int s = 0;
        logic [31:0] sv;
        for (int k = 0; k < 9; k++) s += int'(w[k*8 +: 8]) * int'(c[k]);
`ifdef CONV_SATURATE_EN
        if (s < 0) return 8'd0;
        if (s > 255) return 8'd255;
`endif
        sv = s;
        return sv[7:0];
    endfunction

    function automatic logic [71:0] win_fill(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
        logic [71:0] w;
        for (int r = 0; r < 3; r++) begin
            w[(r*3+0)*8 +: 8] = c0;
            w[(r*3+1)*8 +: 8] = c1;
            w[(r*3+2)*8 +: 8] = c2;
        end
        return w;
    endfunction

    task automatic write_coef(input logic [3:0] a, input logic signed [8:0] d);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        if (a < 4'd9) bank[a] = d;
        @(posedge clk); @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < 9; k++) bank[k] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One full window: accept (optionally with a same-cycle write), optional write
    // during ACCUM, latency check, stall with stability check, handshake.
    task automatic run_window(input string tag, input logic [71:0] w, input int stall,
                              input bit wa, input logic [3:0] aa, input logic signed [8:0] da,
                              input bit wm, input logic [3:0] am, input logic signed [8:0] dm);
        int n;
        int lat;
        logic [7:0] exp;
        bit stable;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        chk({tag, ".ready"}, in_ready, 1);
        in_data = w; in_valid = 1'b1;
        if (wa) begin coef_we = 1'b1; coef_addr = aa; coef_data = da; end
        snap = bank;
        if (wa && aa < 4'd9) bank[aa] = da;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; coef_we = 1'b0;
        chk({tag, ".busy"}, {busy, in_ready}, 2'b10);
        lat = 1;
        while (!out_valid && lat < 30) begin
            if (wm && lat == 3) begin
                coef_we = 1'b1; coef_addr = am; coef_data = dm;
                if (am < 4'd9) bank[am] = dm;
            end
            @(posedge clk); @(negedge clk);
            coef_we = 1'b0;
            lat++;
        end
        chk({tag, ".latency"}, lat, 10);
        exp = model(w, snap);
        chk({tag, ".data"}, out_data, exp);
        stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); @(negedge clk);
            if (!(out_valid === 1'b1 && out_data === exp && in_ready === 1'b0)) stable = 1'b0;
        end
        if (stall > 0) chk({tag, ".stall_stable"}, stable, 1);
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".release"}, {out_valid, in_ready, busy}, 3'b010);
    endtask

    initial begin
        logic signed [8:0] gx [9];
        logic [71:0] w;
        int n;
        gx = '{-9'sd1, 9'sd0, 9'sd1, -9'sd2, 9'sd0, 9'sd2, -9'sd1, 9'sd0, 9'sd1};

        @(negedge clk);
        do_reset();
        chk("reset.outputs", {in_ready, out_valid, busy, out_data}, {3'b100, 8'd0});

        for (int k = 0; k < 9; k++) write_coef(4'(k), gx[k]);
        run_window("gx_flat", win_fill(8'd100, 8'd100, 8'd100), 0, 0, 0, 0, 0, 0, 0);
        run_window("gx_pos", win_fill(8'd0, 8'd0, 8'd255), 20, 0, 0, 0, 0, 0, 0);
        run_window("gx_neg", win_fill(8'd255, 8'd0, 8'd0), 2, 0, 0, 0, 0, 0, 0);

        // Writes during acceptance and during ACCUM must not touch the live window
        w = '0; w[7:0] = 8'd10;
        run_window("coef_old", w, 0, 1, 4'd0, 9'sd5, 1, 4'd0, 9'sd5);
        run_window("coef_new", w, 0, 0, 0, 0, 0, 0, 0);
        chk("coef_new.value", model(w, bank), 8'd50);

        // Out-of-range address is ignored
        write_coef(4'd12, -9'sd7);
        run_window("addr_ignored", win_fill(8'd3, 8'd5, 8'd7), 1, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of ACCUM
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        in_data = win_fill(8'd9, 8'd20, 8'd200); in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 9; k++) bank[k] = '0;
        chk("midrst.outputs", {in_ready, out_valid, busy, out_data}, {3'b100, 8'd0});
        run_window("midrst.after", win_fill(8'd50, 8'd60, 8'd70), 0, 0, 0, 0, 0, 0, 0);

        // Randomized windows and coefficient traffic
        for (int t = 0; t < 10; t++) begin
            for (int j = 0; j < 3; j++)
                write_coef(4'($urandom_range(0, 15)), 9'($urandom_range(0, 511)));
            for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'($urandom_range(0, 255));
            run_window("rand", w, $urandom_range(0, 3),
                       1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 9'($urandom_range(0, 511)),
                       1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 9'($urandom_range(0, 511)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
